// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and default bit timing.
// Imported by my_tx, my_rx and uart_bit_timer.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 87;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Even parity is the XOR of the byte; odd parity is its inverse.
    function automatic logic parity_bit(input logic [7:0] b, input int unsigned mode);
        return (mode == PAR_ODD) ? ~(^b) : (^b);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps; restarts at 0 on clear.
// tick is high while the count sits at its last value, pre_tick one cycle earlier.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick,
    output logic pre_tick
);

    localparam int unsigned     CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] count_q, count_d;
    logic          tick_q, tick_d;
    logic          pre_q, pre_d;

    // Flags are registered from the next count so they line up with count_q.
    always_comb begin
        count_d = count_q + CW'(1);
        if (clear || (count_q == LAST)) begin
            count_d = '0;
        end
        tick_d = (count_d == LAST);
        pre_d  = (count_d == PRE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            tick_q  <= 1'b0;
            pre_q   <= (PRE == '0);
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
            pre_q   <= pre_d;
        end
    end

    assign tick     = tick_q;
    assign pre_tick = pre_q;

endmodule

// File: rtl/my_tx.sv
// UART transmitter: one byte per valid/ready accept, LSB first, optional parity and
// one or two stop bits. ready/done rise together in the last stop-bit cycle for streaming.
module my_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned PARITY       = PAR_NONE,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       done
);

    localparam logic HAS_PARITY = (PARITY != PAR_NONE);
    localparam logic LAST_STOP  = 1'(STOP_BITS - 1);

    uart_state_e state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        stop_idx_q, stop_idx_d;
    logic        tx_q, tx_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;

    logic        accept;
    logic        tick;
    logic        pre_tick;
    logic        last_stop;
    logic        par_bit;
    logic [2:0]  nxt_idx;

    assign accept    = valid && ready_q;
    assign last_stop = (stop_idx_q == LAST_STOP);
    assign par_bit   = parity_bit(data_q, PARITY);
    assign nxt_idx   = bit_idx_q + 3'd1;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        tx_d       = tx_q;
        ready_d    = ready_q;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_START;
                    data_d  = data;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = data_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
                        if (HAS_PARITY) begin
                            state_d = ST_PARITY;
                            tx_d    = par_bit;
                        end else begin
                            state_d    = ST_STOP;
                            stop_idx_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        bit_idx_d = nxt_idx;
                        tx_d      = data_q[nxt_idx];
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d    = ST_STOP;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end
            ST_STOP: begin
                // Raise ready/done one edge early so both are high in the final cycle.
                if (last_stop && pre_tick) begin
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                end
                if (tick) begin
                    if (!last_stop) begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end else if (accept) begin
                        state_d = ST_START;
                        data_d  = data;
                        tx_d    = 1'b0;
                        ready_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign ready = ready_q;
    assign tx    = tx_q;
    assign done  = done_q;

endmodule
